instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-supply end of the control unit interface: owns the PC, fetches
//  from instruction memory (iREN/ihit handshake), holds instr stable for the
//  control unit until commit, then applies PCen/PCsrc/imm_addr/j_addr to form next PC.
//  Sits between icache/memory arbiter and control unit; latches halt, counts retirements.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0000  value driven on instr when no valid instruction held
// PORTS
//  CLK            in   1   clock
//  nRST           in   1   async active-low reset
//  ihit           in   1   imem returns iload this cycle
//  iload          in   32  instruction word from imem
//  PCen           in   1   control unit: PC may advance
//  PCsrc          in   2   next-PC select (00 +4, 01 branch, 10 jump, 11 jr)
//  halt           in   1   control unit: current instr is HALT
//  imm_addr       in   16  branch offset (words, signed)
//  j_addr         in   26  jump target field
//  jr_addr        in   32  rs value for jr
//  pc_stall       in   1   datapath busy (dmem access pending); blocks commit
//  iREN           out  1   imem read request
//  iaddr          out  32  imem address (= pc)
//  instr          out  32  instruction to control unit
//  instr_valid    out  1   instr holds a fetched word
//  pc             out  32  current PC
//  npc            out  32  pc+4 (jal return address)
//  halted         out  1   sticky halt
//  retired_count  out  32  instructions retired
// BEHAVIOUR
//  Reset (async, nRST=0): state=FETCH, pc=PC_INIT, instr_q=NOP_INSTR, instr_valid=0,
//   halted=0, retired_count=0; iREN=1 combinationally from FETCH, so asserted
//   from the first cycle after release, iaddr=PC_INIT.
//  States: FETCH, EXEC, HALTED.
//   FETCH: iREN=1, iaddr=pc. ihit=1 -> instr_q<=iload, instr_valid<=1, ->EXEC.
//   EXEC: iREN=0; instr=instr_q. commit = PCen & ~pc_stall.
//     halt=1 -> halted<=1, retired_count+1, pc unchanged, ->HALTED (halt beats commit).
//     else commit -> pc<=next_pc, instr_valid<=0, retired_count+1, ->FETCH.
//     else hold everything.
//   HALTED: iREN=0, instr_valid=0, pc frozen; exits only via reset.
//  instr = instr_valid ? instr_q : NOP_INSTR. ihit/iload ignored outside FETCH.
//  next_pc (mod 2^32): 00 npc; 01 npc + (sext(imm_addr)<<2);
//   10 {npc[31:28], j_addr, 2'b00}; 11 {jr_addr[31:2], 2'b00}.
//  PCsrc/imm/j/jr sampled only in commit cycle; other cycles don't care.
//  Latency: ihit cycle n -> instr_valid at n+1; commit cycle m -> iREN, new iaddr at m+1.
//  Min 2 cycles/instr (ihit same cycle as iREN).
//  retired_count wraps 32'hFFFF_FFFF -> 0 silently.
//  pc_stall held high in EXEC: no commit, instr stable, counter unchanged.
//  Reset mid-FETCH or mid-EXEC: pending ihit discarded, restart at PC_INIT.
// STRUCTURE
//  cpu_types_pkg: fetch_state_t enum {FETCH, EXEC, HALTED};
//   PCSRC_NEXT/BRANCH/JUMP/JR 2-bit constants; word_t reused.
//  Sub-module pc_next_calc (combinational: pc/PCsrc/imm/j/jr -> next_pc, npc).
//  Top holds FSM, pc, instr_q, counter registers.
// TESTING
//  1 Reset, ihit=1 each FETCH, PCen=1, PCsrc=00 -> iaddr 0,4,8 every 2 cycles; count 3.
//  2 pc=0x10, imm_addr=16'hFFFC, PCsrc=01 commit -> next iaddr 0x04; imm 0x0003 -> 0x20.
//  3 pc=0x8000_0010, j_addr=26'h40, PCsrc=10 -> 0x8000_0100; jr_addr=0x1235, PCsrc=11 -> 0x1234.
//  4 ihit low 5 cycles then iload=0x2001_0005 -> iREN held 6 cycles; instr valid next cycle.
//  5 EXEC, pc_stall=1 for 3 cycles with PCen=1 -> pc, instr, count frozen; commit on drop.
//  6 halt=1 & PCen=1 same cycle -> halted=1, pc unchanged, count+1, iREN stays 0; nRST restarts.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem and control-unit signal bundle of the fetch unit
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  // imem side
  logic        ihit;
  word_t       iload;
  logic        iREN;
  word_t       iaddr;

  // control-unit side
  logic        PCen;
  logic [1:0]  PCsrc;
  logic        halt;
  logic [15:0] imm_addr;
  logic [25:0] j_addr;
  word_t       jr_addr;
  logic        pc_stall;
  word_t       instr;
  logic        instr_valid;
  word_t       pc;
  word_t       npc;
  logic        halted;
  word_t       retired_count;

  // master: the fetch unit itself
  modport master (
    input  ihit, iload, PCen, PCsrc, halt, imm_addr, j_addr, jr_addr, pc_stall,
    output iREN, iaddr, instr, instr_valid, pc, npc, halted, retired_count
  );

  // slave: the memory/control-unit environment around it
  modport slave (
    output ihit, iload, PCen, PCsrc, halt, imm_addr, j_addr, jr_addr, pc_stall,
    input  iREN, iaddr, instr, instr_valid, pc, npc, halted, retired_count
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// rtl/instr_fetch_unit_pc_next_calc.sv - combinational next-PC selection
module pc_next_calc
  import instr_fetch_unit_pkg::*;
(
  input  word_t       pc,
  input  logic [1:0]  pc_src,
  input  logic [15:0] imm_addr,
  input  logic [25:0] j_addr,
  input  word_t       jr_addr,
  output word_t       next_pc,
  output word_t       npc
);

  word_t br_off;
  logic  unused_jr_low;

  assign npc           = pc + 32'd4;
  // Branch offset is in words: sign-extend then scale by 4.
  assign br_off        = {{14{imm_addr[15]}}, imm_addr, 2'b00};
  // jr targets are forced word-aligned, so the low rs bits are dropped.
  assign unused_jr_low = ^jr_addr[1:0];

  // Select the successor PC for the committing instruction.
  always_comb begin
    next_pc = npc;
    unique case (pc_src)
      PCSRC_NEXT:   next_pc = npc;
      PCSRC_BRANCH: next_pc = npc + br_off;
      PCSRC_JUMP:   next_pc = {npc[31:28], j_addr, 2'b00};
      PCSRC_JR:     next_pc = {jr_addr[31:2], 2'b00};
      default:      next_pc = npc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, imem fetch handshake, halt latch and retire counter
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter word_t NOP_INSTR = 32'h0000_0000
) (
  input logic              CLK,
  input logic              nRST,
  instr_fetch_unit_if.master bus
);

  fetch_state_t state;
  word_t        pc_q;
  word_t        instr_q;
  word_t        count_q;
  logic         valid_q;
  logic         halted_q;
  word_t        next_pc;
  word_t        npc;
  logic         commit;

  pc_next_calc u_pc_next_calc (
    .pc       (pc_q),
    .pc_src   (bus.PCsrc),
    .imm_addr (bus.imm_addr),
    .j_addr   (bus.j_addr),
    .jr_addr  (bus.jr_addr),
    .next_pc  (next_pc),
    .npc      (npc)
  );

  // A held instruction retires only when the datapath is not busy.
  assign commit = bus.PCen & ~bus.pc_stall;

  // Fetch/execute/halt sequencing with all architectural state registered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (bus.ihit) begin
            instr_q <= bus.iload;
            valid_q <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // HALT retires but never advances the PC, even if commit is also seen.
          if (bus.halt) begin
            halted_q <= 1'b1;
            valid_q  <= 1'b0;
            count_q  <= count_q + 32'd1;
            state    <= HALTED;
          end else if (commit) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
            count_q <= count_q + 32'd1;
            state   <= FETCH;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.iREN          = (state == FETCH);
  assign bus.iaddr         = pc_q;
  assign bus.pc            = pc_q;
  assign bus.npc           = npc;
  assign bus.instr         = valid_q ? instr_q : NOP_INSTR;
  assign bus.instr_valid   = valid_q;
  assign bus.halted        = halted_q;
  assign bus.retired_count = count_q;

endmodule
